// File: rtl/dsp_pipe_reg.sv
// Configurable-depth operand pipeline register with runtime bypass, per-stage valid
// tracking, an in-flight counter and a pulse for items discarded by bypass.
module dsp_pipe_reg #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 1,
  parameter int CNT_W = (DEPTH < 1) ? 1 : $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             CE,
  input  logic             CLR,
  input  logic             BYPASS,
  input  logic [WIDTH-1:0] D,
  input  logic             D_VLD,
  output logic [WIDTH-1:0] Q,
  output logic             Q_VLD,
  output logic [CNT_W-1:0] INFLIGHT,
  output logic             DROP
);

  generate
    if (DEPTH == 0) begin : g_wire
      assign Q        = D;
      assign Q_VLD    = D_VLD;
      assign INFLIGHT = '0;
      assign DROP     = 1'b0;
      wire unused_ok = &{1'b0, CLK, RST_N, CE, CLR, BYPASS};
    end else begin : g_pipe
      logic [DEPTH-1:0][WIDTH-1:0] data_q, data_d;
      logic [DEPTH-1:0]            vld_q, vld_d;
      logic [CNT_W-1:0]            cnt_q, cnt_d;
      logic                        drop_q, drop_d;

      always_comb begin
        data_d = data_q;
        vld_d  = vld_q;
        drop_d = 1'b0;
        if (CLR) begin
          data_d = '0;
          vld_d  = '0;
        end else begin
          if (CE) begin
            data_d[0] = D;
            vld_d[0]  = D_VLD;
            for (int i = 1; i < DEPTH; i++) begin
              data_d[i] = data_q[i-1];
              vld_d[i]  = vld_q[i-1];
            end
          end
          // Bypass keeps shifting data but invalidates everything, so nothing
          // stale can surface as valid once bypass is released.
          if (BYPASS) begin
            vld_d  = '0;
            drop_d = (cnt_q != '0);
          end
        end
        cnt_d = '0;
        for (int i = 0; i < DEPTH; i++) cnt_d = cnt_d + CNT_W'(vld_d[i]);
      end

      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          data_q <= '0;
          vld_q  <= '0;
          cnt_q  <= '0;
          drop_q <= 1'b0;
        end else begin
          data_q <= data_d;
          vld_q  <= vld_d;
          cnt_q  <= cnt_d;
          drop_q <= drop_d;
        end
      end

      assign Q        = BYPASS ? D     : data_q[DEPTH-1];
      assign Q_VLD    = BYPASS ? D_VLD : vld_q[DEPTH-1];
      assign INFLIGHT = cnt_q;
      assign DROP     = drop_q;
    end
  endgenerate

endmodule

// File: tb/tb_dsp_pipe_reg.sv
// Bench for dsp_pipe_reg: four depths (3, 2, 4, 0) share one stimulus bus; directed
// table and sequences, then random traffic against a history-log reference model.
module tb_dsp_pipe_reg;

  logic        clk = 1'b0;
  logic        rst_n, ce, clr, byp, dvld;
  logic [17:0] d;

  logic [17:0] q3, q2, q4, q0;
  logic        qv3, qv2, qv4, qv0, dr3, dr2, dr4, dr0;
  logic [1:0]  inf3, inf2;
  logic [2:0]  inf4;
  logic [0:0]  inf0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dsp_pipe_reg #(.WIDTH(18), .DEPTH(3)) u3 (
    .CLK(clk), .RST_N(rst_n), .CE(ce), .CLR(clr), .BYPASS(byp), .D(d), .D_VLD(dvld),
    .Q(q3), .Q_VLD(qv3), .INFLIGHT(inf3), .DROP(dr3));
  dsp_pipe_reg #(.WIDTH(18), .DEPTH(2)) u2 (
    .CLK(clk), .RST_N(rst_n), .CE(ce), .CLR(clr), .BYPASS(byp), .D(d), .D_VLD(dvld),
    .Q(q2), .Q_VLD(qv2), .INFLIGHT(inf2), .DROP(dr2));
  dsp_pipe_reg #(.WIDTH(18), .DEPTH(4)) u4 (
    .CLK(clk), .RST_N(rst_n), .CE(ce), .CLR(clr), .BYPASS(byp), .D(d), .D_VLD(dvld),
    .Q(q4), .Q_VLD(qv4), .INFLIGHT(inf4), .DROP(dr4));
  dsp_pipe_reg #(.WIDTH(18), .DEPTH(0)) u0 (
    .CLK(clk), .RST_N(rst_n), .CE(ce), .CLR(clr), .BYPASS(byp), .D(d), .D_VLD(dvld),
    .Q(q0), .Q_VLD(qv0), .INFLIGHT(inf0), .DROP(dr0));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic c, input logic b, input logic cl, input logic [17:0] dd,
                       input logic v);
    ce = c; byp = b; clr = cl; d = dd; dvld = v;
  endtask

  typedef struct {
    logic [17:0] d;
    logic        v, ce;
    logic [17:0] q;
    logic        qv;
    logic [1:0]  inf;
  } vec_t;

  function automatic vec_t mk(input logic [17:0] dd, input logic v, input logic c,
                              input logic [17:0] qq, input logic qv, input logic [1:0] inf);
    vec_t r;
    r.d = dd; r.v = v; r.ce = c; r.q = qq; r.qv = qv; r.inf = inf;
    return r;
  endfunction

  // Reference model: a log of every item accepted into the pipe. The last stage of a
  // DEPTH-k pipe shows the item accepted k acceptances ago; an item is live only if it
  // was valid and no clear/bypass edge has happened since it was accepted.
  logic [17:0] hd [4096];
  logic        hv [4096];
  int          he [4096];
  int          n_acc, epoch;

  function automatic int m_infl(input int k);
    int c = 0;
    for (int j = (n_acc > k) ? n_acc - k : 0; j < n_acc; j++)
      if (hv[j] && he[j] == epoch) c++;
    return c;
  endfunction

  function automatic logic m_qv(input int k);
    if (n_acc < k) return 1'b0;
    return hv[n_acc-k] && (he[n_acc-k] == epoch);
  endfunction

  task automatic chk_inst(input string nm, input int k, input logic [17:0] qq, input logic qv,
                          input int inf, input logic dr, input logic exp_dr);
    if (byp) begin
      chk({nm, ".q_byp"}, qq, d);
      chk({nm, ".qv_byp"}, qv, dvld);
    end else begin
      chk({nm, ".qv"}, qv, m_qv(k));
      if (m_qv(k)) chk({nm, ".q"}, qq, hd[n_acc-k]);
    end
    chk({nm, ".inf"}, inf, m_infl(k));
    chk({nm, ".drop"}, dr, exp_dr);
  endtask

  vec_t tbl[14];

  initial begin
    int pre3, pre2, pre4;
    logic e3, e2, e4;

    tbl[0]  = mk(1, 1, 1, 0, 0, 1);
    tbl[1]  = mk(2, 1, 1, 0, 0, 2);
    tbl[2]  = mk(3, 1, 1, 1, 1, 3);
    tbl[3]  = mk(4, 1, 1, 2, 1, 3);
    tbl[4]  = mk(5, 1, 1, 3, 1, 3);
    tbl[5]  = mk(6, 1, 1, 4, 1, 3);
    tbl[6]  = mk(7, 1, 1, 5, 1, 3);
    tbl[7]  = mk(8, 1, 0, 5, 1, 3);
    tbl[8]  = mk(8, 1, 0, 5, 1, 3);
    tbl[9]  = mk(8, 1, 0, 5, 1, 3);
    tbl[10] = mk(8, 1, 0, 5, 1, 3);
    tbl[11] = mk(0, 0, 1, 6, 1, 2);
    tbl[12] = mk(0, 0, 1, 7, 1, 1);
    tbl[13] = mk(0, 0, 1, 0, 0, 0);

    rst_n = 1'b0;
    drive(1, 0, 0, 0, 0);
    #1;
    chk("rst.q3", q3, 0);   chk("rst.qv3", qv3, 0);
    chk("rst.inf3", inf3, 0); chk("rst.dr3", dr3, 0);
    chk("rst.inf4", inf4, 0); chk("rst.qv2", qv2, 0);
    drive(1, 1, 0, 18'h155, 1);
    #1;
    chk("rst.byp_q3", q3, 18'h155); chk("rst.byp_qv3", qv3, 1);
    drive(1, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // latency ramp, stall, drain with bubbles on DEPTH=3
    foreach (tbl[i]) begin
      drive(tbl[i].ce, 0, 0, tbl[i].d, tbl[i].v);
      tick();
      chk($sformatf("tbl%0d.q", i), q3, tbl[i].q);
      chk($sformatf("tbl%0d.qv", i), qv3, tbl[i].qv);
      chk($sformatf("tbl%0d.inf", i), inf3, tbl[i].inf);
      chk($sformatf("tbl%0d.drop", i), dr3, 0);
    end

    // bypass flush on DEPTH=3
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 18'(11 + i), 1);
      tick();
    end
    chk("flush.inf_pre", inf3, 3); chk("flush.q_pre", q3, 11);
    drive(1, 1, 0, 20, 1);
    #1;
    chk("flush.q_comb", q3, 20); chk("flush.qv_comb", qv3, 1);
    tick();
    chk("flush.drop", dr3, 1); chk("flush.inf", inf3, 0);
    tick();
    chk("flush.drop_1cyc", dr3, 0);
    drive(1, 0, 0, 9, 1);
    #1;
    chk("flush.qv_stale", qv3, 0);
    tick();
    chk("flush.qv_e1", qv3, 0);
    drive(1, 0, 0, 0, 0);
    tick();
    chk("flush.qv_e2", qv3, 0);
    tick();
    chk("flush.qv_e3", qv3, 1); chk("flush.q_e3", q3, 9);

    // CLR beats bypass and CE on DEPTH=2
    drive(1, 0, 0, 31, 1); tick();
    drive(1, 0, 0, 32, 1); tick();
    chk("clr.inf_pre", inf2, 2); chk("clr.q_pre", q2, 31);
    drive(0, 1, 1, 33, 1);
    tick();
    chk("clr.inf", inf2, 0); chk("clr.drop", dr2, 0);
    drive(0, 0, 0, 33, 1);
    #1;
    chk("clr.qv", qv2, 0);
    tick();
    chk("clr.drop_after", dr2, 0);

    // asynchronous reset between edges on DEPTH=4
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 18'(41 + i), 1);
      tick();
    end
    chk("arst.inf_pre", inf4, 4); chk("arst.q_pre", q4, 41);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.q", q4, 0); chk("arst.qv", qv4, 0); chk("arst.inf", inf4, 0);

    // random traffic against the reference model, all depths
    n_acc = 0;
    epoch = 0;
    e3 = 0; e2 = 0; e4 = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
            18'($urandom), $urandom_range(0, 3) != 0);
      pre3 = m_infl(3); pre2 = m_infl(2); pre4 = m_infl(4);
      @(posedge clk);
      e3 = 0; e2 = 0; e4 = 0;
      if (clr) begin
        epoch++;
      end else begin
        if (ce) begin
          hd[n_acc] = d; hv[n_acc] = dvld; he[n_acc] = epoch;
          n_acc++;
        end
        if (byp) begin
          epoch++;
          e3 = (pre3 != 0); e2 = (pre2 != 0); e4 = (pre4 != 0);
        end
      end
      #1;
      chk_inst("r3", 3, q3, qv3, int'(inf3), dr3, e3);
      chk_inst("r2", 2, q2, qv2, int'(inf2), dr2, e2);
      chk_inst("r4", 4, q4, qv4, int'(inf4), dr4, e4);
      chk("r0.q", q0, d); chk("r0.qv", qv0, dvld);
      chk("r0.inf", inf0, 0); chk("r0.drop", dr0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dsp_pipe_reg.md
Name: dsp_pipe_reg

Overview:
Parametrised pipeline register for the DSP48A1 datapath. It generalises the fixed registered/combinational select into three things: a configurable stage count, a runtime bypass, and valid tracking. Each stage has its own data and valid flag, and the block reports in-flight occupancy and discarded items. It is instantiated on the A/B/C/D/M/P operand paths in place of a flop plus a select mux.

Parameters:
WIDTH, 18, data width in bits (1..48)
DEPTH, 1, number of register stages (0..8); 0 gives a pure wire path
CNT_W, derived: $clog2(DEPTH+1), minimum 1, width of INFLIGHT

Ports:
CLK  in  1  rising-edge clock
RST_N  in  1  asynchronous active-low reset
CE  in  1  clock enable for the stage shift
CLR  in  1  synchronous clear of all stages
BYPASS  in  1  runtime mode select: 1 = combinational, 0 = registered
D  in  WIDTH  input data
D_VLD  in  1  input valid
Q  out  WIDTH  output data
Q_VLD  out  1  output valid
INFLIGHT  out  CNT_W  number of stages currently holding valid data
DROP  out  1  one-cycle pulse: valid items were discarded by bypass

Behaviour:
- Storage: stage[0..DEPTH-1] each holds data (WIDTH bits) and vld (1 bit). stage[0] is nearest the input.
- Reset (RST_N=0, asynchronous): all stage data=0, all vld=0, DROP=0, INFLIGHT=0. Outputs during reset follow the mux: with BYPASS=0, Q=0 and Q_VLD=0; with BYPASS=1, Q=D and Q_VLD=D_VLD.
- Release of reset is synchronised by the integrator. The first edge with RST_N=1 is a normal edge.
- Priority at each rising edge, highest first:
  1. CLR=1: all data=0, all vld=0, DROP<=0. Applies regardless of CE or BYPASS.
  2. BYPASS=1: all vld<=0. DROP<=1 if INFLIGHT!=0 before the edge, else 0. Stage data still shifts if CE=1 and holds if CE=0.
  3. CE=1: stage[0]<=(D, D_VLD); stage[i]<=stage[i-1] for i>=1. DROP<=0.
  4. CE=0: all stages hold. DROP<=0.
- Output mux (combinational):
  - BYPASS=1: Q=D, Q_VLD=D_VLD.
  - BYPASS=0: Q=stage[DEPTH-1].data, Q_VLD=stage[DEPTH-1].vld.
- Latency with BYPASS=0 and CE held at 1: D to Q is exactly DEPTH cycles. With BYPASS=1 it is 0 cycles.
- CE=0 stalls the pipe. Q and Q_VLD hold their last stage values, so the stall is lossless.
- INFLIGHT: registered popcount of stage vld, updated on the same edge as the stages. Range 0..DEPTH, no overflow possible.
- DROP: registered, high for exactly one cycle after the discarding edge.
- Bypass is sticky-clean. While BYPASS=1, vld is cleared at every edge. After a 1->0 transition, Q_VLD=0 until the first item accepted after the transition reaches the last stage. No stale data is ever presented as valid.
- If BYPASS toggles 0->1 on an edge where CLR=1, CLR wins and DROP=0.
- Bubbles: D_VLD=0 with CE=1 inserts a bubble. Data still shifts; only vld marks validity.
- DEPTH=0: Q=D and Q_VLD=D_VLD always. BYPASS, CE and CLR are ignored. INFLIGHT=0 and DROP=0 constant. No flops are inferred.
- Stage data bits have no reset dependency on vld. The verification environment checks Q only when Q_VLD=1, except for the reset value check.

Test Plan:
- Reset and latency (DEPTH=3, WIDTH=18, BYPASS=0, CE=1): hold RST_N=0 then release, drive D=1,2,3,4 with D_VLD=1 -> Q=0 and Q_VLD=0 for 3 cycles, then Q=1,2,3,4 on consecutive cycles; INFLIGHT ramps 1,2,3 and stays at 3.
- Stall (DEPTH=3): while the pipe holds 5,6,7, drop CE to 0 for 4 cycles -> Q=5 and INFLIGHT=3 frozen; after CE returns to 1, Q=6 then 7, with no item lost or duplicated.
- Bypass flush (DEPTH=3): with 3 items in flight, set BYPASS=1 -> Q follows D in the same cycle, DROP=1 for exactly one cycle, INFLIGHT=0. Clear BYPASS and send D=9 -> Q_VLD=0 for 2 cycles, then Q=9 with Q_VLD=1 on the 3rd edge after acceptance.
- CLR priority (DEPTH=2): assert CLR=1 together with CE=0 and BYPASS rising -> all vld cleared, INFLIGHT=0, DROP stays 0.
- Async reset mid-stream (DEPTH=4): pull RST_N low between clock edges with 4 items in flight -> Q=0, Q_VLD=0, INFLIGHT=0 immediately, without waiting for an edge.
- DEPTH=0 build: random D, D_VLD, CE, CLR and BYPASS for 1000 cycles -> Q==D and Q_VLD==D_VLD every cycle; INFLIGHT=0 and DROP=0 throughout.
